// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: merges NREQ requesters onto the register file's single registered write port.
// Define RF_WB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 3,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_dst,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr,
    output logic [AW-1:0]        wr_dst,
    output logic [DW-1:0]        wr_data,
    output logic [IW-1:0]        grant_id
);

    logic [AW-1:0] dst_arr  [NREQ];
    logic [DW-1:0] data_arr [NREQ];
    logic [IW-1:0] win_idx;
    logic [IW-1:0] scan_idx;
    logic          win_found;
    logic          grant;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dst_arr[g]  = req_dst[g*AW +: AW];
        assign data_arr[g] = req_data[g*DW +: DW];
    end

`ifdef RF_WB_RR_EN
    logic [IW-1:0] ptr;
`endif

    // First valid requester in scan order; scan starts at ptr (round-robin) or 0 (fixed).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef RF_WB_RR_EN
            scan_idx = IW'((int'(ptr) + k) % NREQ);
`else
            scan_idx = IW'(k);
`endif
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign grant     = win_found & ~rst;
    assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr       <= 1'b0;
            wr_dst   <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            wr <= grant;
            if (grant) begin
                wr_dst   <= dst_arr[win_idx];
                wr_data  <= data_arr[win_idx];
                grant_id <= win_idx;
            end
        end
    end

`ifdef RF_WB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps plus randomized traffic against a scan-order model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [8:0]  req_dst;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wr;
    logic [2:0]  wr_dst;
    logic [31:0] wr_data;
    logic [1:0]  grant_id;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr        (wr),
        .wr_dst    (wr_dst),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          m_ptr = 0;
    int          last_w;
    logic        exp_wr   = 1'b0;
    logic [2:0]  exp_dst  = '0;
    logic [31:0] exp_data = '0;
    logic [1:0]  exp_gid  = '0;
    logic [2:0]  obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Winner = first valid index scanning from the priority pointer (round-robin) or from 0.
    function automatic int model_winner(input logic [2:0] v);
        int idx;
        for (int k = 0; k < 3; k++) begin
`ifdef RF_WB_RR_EN
            idx = (m_ptr + k) % 3;
`else
            idx = k;
`endif
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic step(input logic [2:0] v, input logic [8:0] d, input logic [95:0] dat);
        int w;
        logic [2:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_dst   = d;
        req_data  = dat;
        #1;
        w = model_winner(v);
        exp_ready = (w < 0) ? 3'b000 : 3'(1 << w);
        obs_ready = req_ready;
        chk("ready", {29'd0, obs_ready}, {29'd0, exp_ready});
        @(posedge clk);
        #1;
        if (w >= 0) begin
            exp_wr   = 1'b1;
            exp_dst  = d[w*3 +: 3];
            exp_data = dat[w*32 +: 32];
            exp_gid  = 2'(w);
            m_ptr    = (w + 1) % 3;
        end else begin
            exp_wr = 1'b0;
        end
        last_w = w;
        chk("wr",       {31'd0, wr},       {31'd0, exp_wr});
        chk("wr_dst",   {29'd0, wr_dst},   {29'd0, exp_dst});
        chk("wr_data",  wr_data,           exp_data);
        chk("grant_id", {30'd0, grant_id}, {30'd0, exp_gid});
    endtask

    // Called just after a rising edge: asserts reset mid-cycle, checks the immediate clear, releases next edge.
    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        chk("rst_wr",       {31'd0, wr},        32'd0);
        chk("rst_ready",    {29'd0, req_ready}, 32'd0);
        chk("rst_wr_dst",   {29'd0, wr_dst},    32'd0);
        chk("rst_wr_data",  wr_data,            32'd0);
        chk("rst_grant_id", {30'd0, grant_id},  32'd0);
        m_ptr    = 0;
        exp_wr   = 1'b0;
        exp_dst  = '0;
        exp_data = '0;
        exp_gid  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic        pv   [3];
    logic [2:0]  pd   [3];
    logic [31:0] pdat [3];
    logic [2:0]  rv;
    logic [8:0]  rd;
    logic [95:0] rdat;
`ifndef RF_WB_RR_EN
    logic [2:0]  fp_valid;
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dst   = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1 req_valid = 3'b111;
        #1;
        chk("init_wr",       {31'd0, wr},        32'd0);
        chk("init_ready",    {29'd0, req_ready}, 32'd0);
        chk("init_wr_dst",   {29'd0, wr_dst},    32'd0);
        chk("init_wr_data",  wr_data,            32'd0);
        chk("init_grant_id", {30'd0, grant_id},  32'd0);
        rst = 1'b0;

`ifdef RF_WB_RR_EN
        for (int i = 0; i < 6; i++) begin
            step(3'b111, {3'd3, 3'd2, 3'd1}, {32'hC0 + 32'(i), 32'hB0 + 32'(i), 32'hA0 + 32'(i)});
            if (i == 0) chk("rel_ready", {29'd0, obs_ready}, 32'd1);
            chk("rr_seq", {30'd0, grant_id}, 32'(i % 3));
            chk("rr_wr_hold", {31'd0, wr}, 32'd1);
        end
`else
        for (int i = 0; i < 5; i++) begin
            fp_valid = (i < 3) ? 3'b111 : ((i == 3) ? 3'b110 : 3'b100);
            step(fp_valid, {3'd3, 3'd2, 3'd1}, {32'hC0 + 32'(i), 32'hB0 + 32'(i), 32'hA0 + 32'(i)});
            if (i == 0) chk("rel_ready", {29'd0, obs_ready}, 32'd1);
            chk("fp_seq", {30'd0, grant_id}, (i < 3) ? 32'd0 : 32'(i - 2));
            chk("fp_wr_hold", {31'd0, wr}, 32'd1);
        end
`endif

        step(3'b000, 9'd0, 96'd0);
        chk("idle_wr", {31'd0, wr}, 32'd0);

        step(3'b010, {3'd0, 3'd5, 3'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
        chk("single_ready", {29'd0, obs_ready}, 32'b010);
        chk("single_wr",    {31'd0, wr},        32'd1);
        chk("single_dst",   {29'd0, wr_dst},    32'd5);
        chk("single_data",  wr_data,            32'hDEADBEEF);
        chk("single_gid",   {30'd0, grant_id},  32'd1);
        step(3'b000, 9'd0, 96'd0);
        chk("single_after_wr",  {31'd0, wr},     32'd0);
        chk("single_hold_dst",  {29'd0, wr_dst}, 32'd5);
        chk("single_hold_data", wr_data,         32'hDEADBEEF);

        // Last grant was requester 1, so the pointer sits at 2: scan wraps to 0.
        step(3'b011, {3'd0, 3'd6, 3'd4}, {32'd0, 32'h1111, 32'h0000});
        chk("wrap_ready0", {29'd0, obs_ready}, 32'b001);
        chk("wrap_gid0",   {30'd0, grant_id},  32'd0);
        step(3'b010, {3'd0, 3'd6, 3'd4}, {32'd0, 32'h1111, 32'h0000});
        chk("wrap_ready1", {29'd0, obs_ready}, 32'b010);
        chk("wrap_gid1",   {30'd0, grant_id},  32'd1);

        step(3'b111, {3'd7, 3'd6, 3'd5}, {32'h333, 32'h222, 32'h111});
        chk("burst_wr", {31'd0, wr}, 32'd1);
        reset_pulse();
        step(3'b111, {3'd7, 3'd6, 3'd5}, {32'h333, 32'h222, 32'h111});
        chk("post_rst_ready", {29'd0, obs_ready}, 32'b001);
        chk("post_rst_gid",   {30'd0, grant_id},  32'd0);

        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]   = 1'b1;
                    pd[i]   = 3'($urandom_range(0, 7));
                    pdat[i] = $urandom;
                end else if (pv[i] && $urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
                rv[i]            = pv[i];
                rd[i*3 +: 3]     = pd[i];
                rdat[i*32 +: 32] = pdat[i];
            end
            step(rv, rd, rdat);
            if (last_w >= 0) pv[last_w] = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse();
                for (int i = 0; i < 3; i++) pv[i] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
